free_list: RTL and testbench

FREE_LIST -- requirements
Module: free_list

---
 rtl/free_list_pkg.sv | 15 +
 rtl/free_list.sv | 75 +++++++
 tb/tb_free_list.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/free_list_pkg.sv
// free_list_pkg: shared sizes and packet types for the rename free list
package free_list_pkg;
  localparam int NUM_PREGS = 64;
  localparam int NUM_ARCH_REGS = 32;
  localparam int PREG_IDX_W = $clog2(NUM_PREGS);
  localparam int FL_DEPTH = NUM_PREGS - NUM_ARCH_REGS;
  typedef struct packed {
    logic                  valid;
    logic [PREG_IDX_W-1:0] tag;
  } FL_ALLOC_OUTPACKET;
  typedef struct packed {
    logic                  valid;
    logic [PREG_IDX_W-1:0] tag;
  } FL_RETIRE_INPACKET;
endpackage

// File: rtl/free_list.sv
// free_list: circular FIFO of free physical tags with speculative and committed read heads
module free_list
  import free_list_pkg::*;
#(
  parameter int numOfRequests = 2,
  parameter int numOfPregs = NUM_PREGS,
  parameter int numOfArchRegs = NUM_ARCH_REGS
) (
  input  logic                                      clock,
  input  logic                                      reset,
  input  logic [numOfRequests-1:0]                  dispatch_req,
  output logic [numOfRequests-1:0]                  alloc_valid,
  output logic [numOfRequests-1:0][PREG_IDX_W-1:0]  alloc_tag,
  output logic                                      stall,
  input  logic [numOfRequests-1:0]                  retire_valid,
  input  logic [numOfRequests-1:0][PREG_IDX_W-1:0]  retire_tag,
  input  logic                                      recover,
  output logic [$clog2(numOfPregs-numOfArchRegs):0] free_count
);
  localparam int DEPTH = numOfPregs - numOfArchRegs;
  localparam int IW = $clog2(DEPTH);
  localparam int CW = IW + 1;
  logic [PREG_IDX_W-1:0] r_entry [DEPTH];
  logic [CW-1:0] r_tail, r_spec_head, r_arch_head;
  logic [CW-1:0] w_count, w_nreq, w_nret, w_arch_next;
  logic [numOfRequests-1:0][CW-1:0] w_req_pre, w_ret_pre;
  logic [numOfRequests-1:0][IW-1:0] w_rd_idx, w_wr_idx;
  logic w_grant;
  FL_ALLOC_OUTPACKET w_alloc [numOfRequests];
  always_comb begin
    w_nreq = '0;
    w_nret = '0;
    w_req_pre = '0;
    w_ret_pre = '0;
    for (int i = 0; i < numOfRequests; i++) begin
      w_req_pre[i] = w_nreq;
      w_ret_pre[i] = w_nret;
      w_nreq = w_nreq + CW'(dispatch_req[i]);
      w_nret = w_nret + CW'(retire_valid[i]);
    end
  end
  assign w_count = r_tail - r_spec_head;
  assign w_arch_next = r_arch_head + w_nret;
  // all-or-nothing grant; reset and recover both suppress it
  assign w_grant = reset && !recover && (w_nreq <= w_count);
  always_comb begin
    for (int i = 0; i < numOfRequests; i++) begin
      w_rd_idx[i] = r_spec_head[IW-1:0] + w_req_pre[i][IW-1:0];
      w_wr_idx[i] = r_tail[IW-1:0] + w_ret_pre[i][IW-1:0];
      w_alloc[i].valid = w_grant && dispatch_req[i];
      w_alloc[i].tag = r_entry[w_rd_idx[i]];
      alloc_valid[i] = w_alloc[i].valid;
      alloc_tag[i] = w_alloc[i].tag;
    end
  end
  assign stall = reset && (|dispatch_req) && !w_grant;
  assign free_count = w_count;
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_tail <= CW'(DEPTH);
      r_spec_head <= '0;
      r_arch_head <= '0;
      for (int k = 0; k < DEPTH; k++) r_entry[k] <= PREG_IDX_W'(numOfArchRegs + k);
    end else begin
      for (int i = 0; i < numOfRequests; i++)
        if (retire_valid[i]) r_entry[w_wr_idx[i]] <= retire_tag[i];
      r_tail <= r_tail + w_nret;
      r_arch_head <= w_arch_next;
      r_spec_head <= recover ? w_arch_next : r_spec_head + (w_grant ? w_nreq : '0);
    end
  end
  // retiring more tags than there are slots would overwrite live entries
  assert property (@(posedge clock) disable iff (!reset)
    ({1'b0, w_count} + {1'b0, w_nret}) <= (CW+1)'(DEPTH));
endmodule

// File: tb/tb_free_list.sv
// tb_free_list: directed and randomized checks of free_list against a tag-queue model
module tb_free_list;
  localparam int D = 32;
  logic clock = 1'b0;
  always #5 clock = ~clock;
  logic reset, stall, recover;
  logic [1:0] dispatch_req, alloc_valid, retire_valid;
  logic [1:0][5:0] alloc_tag, retire_tag;
  logic [5:0] free_count;
  int tests = 0;
  int fails = 0;
  logic [5:0] q[$];
  int used;
  logic m_g;

  free_list dut (
    .clock(clock), .reset(reset), .dispatch_req(dispatch_req),
    .alloc_valid(alloc_valid), .alloc_tag(alloc_tag), .stall(stall),
    .retire_valid(retire_valid), .retire_tag(retire_tag),
    .recover(recover), .free_count(free_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    for (int k = 0; k < D; k++) q.push_back(6'(32 + k));
    used = 0;
    m_g = 1'b0;
  endtask

  task automatic drive(input logic [1:0] req, input logic [1:0] rv,
                       input logic [5:0] t0, input logic [5:0] t1, input logic rec);
    int nreq, fc, k;
    dispatch_req = req;
    retire_valid = rv;
    retire_tag = {t1, t0};
    recover = rec;
    #1;
    nreq = int'(req[0]) + int'(req[1]);
    fc = D - used;
    m_g = !rec && nreq <= fc;
    chk("free_count", free_count, fc);
    chk("stall", stall, (req != 0) && !m_g);
    chk("alloc_valid", alloc_valid, m_g ? req : 2'b00);
    k = 0;
    for (int i = 0; i < 2; i++)
      if (m_g && req[i]) begin
        chk("alloc_tag", alloc_tag[i], q[used + k]);
        k++;
      end
  endtask

  task automatic tick();
    @(posedge clock);
    if (m_g) used += int'(dispatch_req[0]) + int'(dispatch_req[1]);
    for (int i = 0; i < 2; i++)
      if (retire_valid[i]) begin
        void'(q.pop_front());
        q.push_back(retire_tag[i]);
        used--;
      end
    if (recover) used = 0;
    @(negedge clock);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    dispatch_req = '0;
    retire_valid = '0;
    retire_tag = '0;
    recover = 1'b0;
    model_reset();
    @(posedge clock);
    @(negedge clock);
    #1;
    chk("rst_free_count", free_count, D);
    dispatch_req = 2'b11;
    #1;
    chk("rst_alloc_valid", alloc_valid, 2'b00);
    chk("rst_stall", stall, 1'b0);
    dispatch_req = '0;
    @(negedge clock);
    reset = 1'b1;
  endtask

  initial begin
    logic [1:0] req, rv;
    logic rec;
    int heavy;
    do_reset();
    drive(2'b11, 2'b00, 0, 0, 0);
    chk("r30_tag0", alloc_tag[0], 32);
    chk("r30_tag1", alloc_tag[1], 33);
    chk("r30_valid", alloc_valid, 2'b11);
    tick();
    drive(2'b11, 2'b00, 0, 0, 0);
    chk("r30_free", free_count, 30);
    chk("r30_tag0b", alloc_tag[0], 34);
    chk("r30_tag1b", alloc_tag[1], 35);
    tick();
    do_reset();
    drive(2'b10, 2'b00, 0, 0, 0);
    chk("r31_tag1", alloc_tag[1], 32);
    chk("r31_valid", alloc_valid, 2'b10);
    tick();
    drive(2'b00, 2'b00, 0, 0, 0);
    chk("r31_free", free_count, 31);
    tick();
    do_reset();
    for (int c = 0; c < 16; c++) begin
      drive(2'b11, 2'b00, 0, 0, 0);
      tick();
    end
    drive(2'b01, 2'b00, 0, 0, 0);
    chk("r32_free", free_count, 0);
    chk("r32_stall", stall, 1'b1);
    chk("r32_valid", alloc_valid, 2'b00);
    drive(2'b01, 2'b01, 5, 0, 0);
    chk("r33_stall", stall, 1'b1);
    tick();
    drive(2'b01, 2'b00, 0, 0, 0);
    chk("r33_free", free_count, 1);
    chk("r33_tag0", alloc_tag[0], 5);
    chk("r33_valid", alloc_valid, 2'b01);
    drive(2'b11, 2'b00, 0, 0, 0);
    chk("r33_stall2", stall, 1'b1);
    tick();
    do_reset();
    for (int c = 0; c < 3; c++) begin
      drive(2'b11, 2'b00, 0, 0, 0);
      tick();
    end
    drive(2'b11, 2'b11, 1, 2, 1);
    chk("r34_valid", alloc_valid, 2'b00);
    tick();
    drive(2'b11, 2'b00, 0, 0, 0);
    chk("r34_free", free_count, 32);
    chk("r34_tag0", alloc_tag[0], 34);
    chk("r34_tag1", alloc_tag[1], 35);
    tick();
    drive(2'b11, 2'b00, 0, 0, 0);
    #1 reset = 1'b0;
    #1;
    chk("r35_free", free_count, D);
    chk("r35_valid", alloc_valid, 2'b00);
    chk("r35_stall", stall, 1'b0);
    model_reset();
    dispatch_req = '0;
    @(negedge clock);
    reset = 1'b1;
    drive(2'b01, 2'b00, 0, 0, 0);
    chk("r35_tag0", alloc_tag[0], 32);
    tick();
    for (int c = 0; c < 800; c++) begin
      heavy = (c / 40) % 2;
      req = (heavy == 1) ? (($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00)
                         : 2'($urandom_range(0, 3));
      rv = (heavy == 1) ? 2'($urandom_range(0, 3))
                        : (($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00);
      if (int'(rv[0]) + int'(rv[1]) > used) rv = (used > 0) ? 2'b01 : 2'b00;
      rec = ($urandom_range(0, 19) == 0);
      drive(req, rv, 6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)), rec);
      tick();
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
